// File: rtl/data_store_buffer_if.sv
// data_store_buffer_if: core data port, data_mem port and buffer status of the store buffer.
interface data_store_buffer_if #(parameter int DEPTH = 4);
    logic                   core_ce_i;
    logic                   core_we_i;
    logic [31:0]            core_addr_i;
    logic [31:0]            core_wdata_i;
    logic [31:0]            core_rdata_o;
    logic                   stall_o;
    logic                   mem_ce_o;
    logic                   mem_we_o;
    logic [31:0]            mem_addr_o;
    logic [31:0]            mem_wdata_o;
    logic [31:0]            mem_rdata_i;
    logic                   empty_o;
    logic [$clog2(DEPTH):0] count_o;
    modport slave (
        input  core_ce_i, core_we_i, core_addr_i, core_wdata_i, mem_rdata_i,
        output core_rdata_o, stall_o, mem_ce_o, mem_we_o, mem_addr_o, mem_wdata_o, empty_o, count_o
    );
    modport master (
        output core_ce_i, core_we_i, core_addr_i, core_wdata_i, mem_rdata_i,
        input  core_rdata_o, stall_o, mem_ce_o, mem_we_o, mem_addr_o, mem_wdata_o, empty_o, count_o
    );
endinterface

// File: rtl/data_store_buffer.sv
// data_store_buffer: posted-write store buffer with in-order drain and store-to-load forwarding.
// Define STORE_BUF_FWD_EN to forward buffered data to loads; otherwise matching loads stall until drained.
module data_store_buffer #(
    parameter int DEPTH        = 4,
    parameter int STARVE_LIMIT = 8
) (
    input logic               clk,
    input logic               rst_n,
    data_store_buffer_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int SW = $clog2(STARVE_LIMIT + 1);

    logic [31:0]   addr_q [DEPTH];
    logic [31:0]   data_q [DEPTH];
    logic [AW-1:0] head_q, head_d, tail_q, tail_d, idx;
    logic [AW:0]   count_q, count_d;
    logic [SW-1:0] starve_q, starve_d;
    logic          load, store, busy, force_drain, hit, hit_stall, rd_port, drain, stall;
    logic [31:0]   fwd_data;

    // Scan oldest to youngest so the last match is the youngest store.
    always_comb begin
        hit      = 1'b0;
        fwd_data = '0;
        idx      = head_q;
        for (int i = 0; i < DEPTH; i++) begin
            idx = head_q + AW'(i);
            if (i < int'(count_q) && addr_q[idx] == bus.core_addr_i) begin
                hit      = 1'b1;
                fwd_data = data_q[idx];
            end
        end
    end

    always_comb begin
        load        = bus.core_ce_i & ~bus.core_we_i;
        store       = bus.core_ce_i & bus.core_we_i;
        busy        = count_q != '0;
        force_drain = busy && starve_q == SW'(STARVE_LIMIT);
`ifdef STORE_BUF_FWD_EN
        hit_stall   = 1'b0;
`else
        hit_stall   = hit;
`endif
        rd_port     = load & ~hit & ~force_drain;
        drain       = busy & ~rd_port;
        stall       = load & (force_drain | hit_stall);
        head_d      = drain ? head_q + 1'b1 : head_q;
        tail_d      = store ? tail_q + 1'b1 : tail_q;
        count_d     = count_q + (AW+1)'(store) - (AW+1)'(drain);
        starve_d    = (!busy || drain) ? '0 :
                      (rd_port && starve_q != SW'(STARVE_LIMIT)) ? starve_q + 1'b1 : starve_q;
    end

    // Combinational outputs are held quiet while reset is asserted.
    always_comb begin
        bus.mem_ce_o     = rst_n & (rd_port | drain);
        bus.mem_we_o     = rst_n & drain;
        bus.mem_addr_o   = drain ? addr_q[head_q] : bus.core_addr_i;
        bus.mem_wdata_o  = data_q[head_q];
        bus.stall_o      = rst_n & stall;
        bus.core_rdata_o = (!rst_n || !load || stall) ? '0 : (hit ? fwd_data : bus.mem_rdata_i);
        bus.empty_o      = count_q == '0;
        bus.count_o      = count_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q   <= '0;
            tail_q   <= '0;
            count_q  <= '0;
            starve_q <= '0;
        end else begin
            head_q   <= head_d;
            tail_q   <= tail_d;
            count_q  <= count_d;
            starve_q <= starve_d;
        end
    end

    always_ff @(posedge clk) begin
        if (store) begin
            addr_q[tail_q] <= bus.core_addr_i;
            data_q[tail_q] <= bus.core_wdata_i;
        end
    end
endmodule

// File: tb/tb_data_store_buffer.sv
// tb_data_store_buffer: randomized scoreboard bench for data_store_buffer with a queue-based reference model.
module tb_data_store_buffer;
    localparam int DEPTH        = 4;
    localparam int STARVE_LIMIT = 8;

    typedef struct {
        logic        stall, mce, mwe, rchk, empty;
        logic [31:0] maddr, mwdata, rdata;
        int          cnt;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   failures = 0;

    data_store_buffer_if #(.DEPTH(DEPTH)) bus ();
    data_store_buffer #(.DEPTH(DEPTH), .STARVE_LIMIT(STARVE_LIMIT)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;

    logic [31:0] tb_mem  [256];
    logic [31:0] ref_mem [256];
    exp_t        exp_q [$];
    logic [31:0] mq_a [$];
    logic [31:0] mq_d [$];
    int          starve = 0;
    logic        p_stall = 1'b0, p_ce = 1'b0, p_we = 1'b0;
    logic [31:0] p_a = '0, p_d = '0;

    assign bus.mem_rdata_i = tb_mem[bus.mem_addr_o[9:2]];

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h at %0t", n, act, req, $time);
        end
    endtask

    // Monitor: owns the data_mem model and compares every presented cycle with the scoreboard.
    initial begin
        exp_t e;
        for (int i = 0; i < 256; i++) tb_mem[i] = '0;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("count", 32'(bus.count_o), 32'(e.cnt));
                chk("empty", 32'(bus.empty_o), 32'(e.empty));
                chk("stall", 32'(bus.stall_o), 32'(e.stall));
                chk("mem_ce", 32'(bus.mem_ce_o), 32'(e.mce));
                if (e.mce) begin
                    chk("mem_we", 32'(bus.mem_we_o), 32'(e.mwe));
                    chk("mem_addr", bus.mem_addr_o, e.maddr);
                    if (e.mwe) chk("mem_wdata", bus.mem_wdata_o, e.mwdata);
                end
                if (e.rchk) chk("rdata", bus.core_rdata_o, e.rdata);
            end
            if (bus.mem_ce_o && bus.mem_we_o) tb_mem[bus.mem_addr_o[9:2]] = bus.mem_wdata_o;
        end
    end

    task automatic step(input logic rn, input logic ce, input logic we, input logic [31:0] a, input logic [31:0] d);
        exp_t        e;
        logic        ld, hit, frc, drn, took;
        logic [31:0] fwd, ha;
        int          n;
        if (p_stall && rn) begin
            ce = p_ce; we = p_we; a = p_a; d = p_d;
        end
        @(posedge clk); #1;
        rst_n = rn;
        bus.core_ce_i = ce; bus.core_we_i = we; bus.core_addr_i = a; bus.core_wdata_i = d;
        e = '{default: 0};
        n = mq_a.size();
        e.rchk = !rn || !ce;
        if (!rn) begin
            mq_a.delete(); mq_d.delete();
            starve = 0; p_stall = 1'b0;
            e.empty = 1'b1;
        end else begin
            e.cnt = n; e.empty = (n == 0);
            hit = 1'b0; fwd = '0;
            for (int i = 0; i < n; i++) if (mq_a[i] == a) begin hit = 1'b1; fwd = mq_d[i]; end
            ld = ce && !we;
            frc = n > 0 && starve == STARVE_LIMIT;
            drn = 1'b0; took = 1'b0;
            if (frc) begin
                drn = 1'b1; e.stall = ld;
            end else if (ld && !hit) begin
                took = 1'b1; e.mce = 1'b1; e.maddr = a; e.rdata = ref_mem[a[9:2]]; e.rchk = 1'b1;
            end else if (n > 0) begin
                drn = 1'b1;
`ifdef STORE_BUF_FWD_EN
                if (ld) begin e.rdata = fwd; e.rchk = 1'b1; end
`else
                if (ld) e.stall = 1'b1;
`endif
            end
            if (drn) begin
                ha = mq_a.pop_front();
                e.mce = 1'b1; e.mwe = 1'b1; e.maddr = ha; e.mwdata = mq_d.pop_front();
                ref_mem[ha[9:2]] = e.mwdata;
            end
            if (n == 0 || drn) starve = 0;
            else if (took && starve < STARVE_LIMIT) starve++;
            if (ce && we) begin mq_a.push_back(a); mq_d.push_back(d); end
            p_stall = e.stall;
        end
        p_ce = ce; p_we = we; p_a = a; p_d = d;
        exp_q.push_back(e);
    endtask

    initial begin
        int bad;
        for (int i = 0; i < 256; i++) ref_mem[i] = '0;
        bus.core_ce_i = 1'b0; bus.core_we_i = 1'b0; bus.core_addr_i = '0; bus.core_wdata_i = '0;
        step(0, 1, 1, 32'h10, 32'h55);
        step(0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) step(1, 1, 1, 32'h10 + 32'(4 * i), 32'(i + 1));
        for (int i = 0; i < 4; i++) step(1, 0, 0, 0, 0);
        for (int i = 0; i < 6; i++) step(1, 1, 1, 32'h40 + 32'(4 * i), 32'hC0 + 32'(i));
        for (int i = 0; i < 2; i++) step(1, 0, 0, 0, 0);
        step(1, 1, 1, 32'h20, 32'hAAAA);
        step(1, 1, 1, 32'h20, 32'hBBBB);
        for (int i = 0; i < 3; i++) step(1, 1, 0, 32'h20, 0);
        step(1, 0, 0, 0, 0);
        step(1, 1, 1, 32'h30, 32'h5);
        for (int i = 0; i < 12; i++) step(1, 1, 0, 32'h100, 0);
        step(1, 1, 1, 32'h34, 32'h6);
        step(1, 1, 1, 32'h38, 32'h7);
        step(0, 1, 1, 32'h3C, 32'h8);
        step(0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 0);
        for (int i = 0; i < 600; i++)
            step($urandom_range(0, 99) != 0, $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
                 32'h100 + 32'(4 * $urandom_range(0, 7)), $urandom);
        for (int i = 0; i < 12; i++) step(1, 0, 0, 0, 0);
        @(posedge clk); #1;
        @(negedge clk); #1;
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        chk("model_drained", 32'(mq_a.size()), 32'd0);
        bad = 0;
        for (int i = 0; i < 256; i++) if (tb_mem[i] !== ref_mem[i]) bad++;
        chk("mem_final", 32'(bad), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
